// File: rtl/linefill_engine_pkg.sv
// Shared types and constants for the cache line-fill / writeback engine.
// Holds the bus FSM state encoding and the default line geometry.
// No logic lives here; every engine file imports this package.
package linefill_engine_pkg;

    // Bus-side FSM states: waiting for a request, moving beats, one-cycle cooldown.
    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_BURST = 2'd1,
        STATE_DONE  = 2'd2
    } busstate_t;

    localparam int DEF_BEATLEN  = 64;
    localparam int BEATSPERLINE = 8;
    localparam int DEF_LINELEN  = BEATSPERLINE * DEF_BEATLEN;

    // Beats needed to move one cache line over the bus.
    function automatic int beats_per_line(input int linelen, input int beatlen);
        return linelen / beatlen;
    endfunction

endpackage

// File: rtl/linefill_engine_beatcounter.sv
// Beat index counter for one line burst; wraps to zero after the last beat.
// Latency: Count updates one cycle after En; Last is combinational from Count.
// Backpressure: none, En is the bus-accept strobe; Clear holds the count at zero.
// Ports: clk, reset (sync, active-high), Clear, En, Count (beat index), Last (final beat).
module linefill_engine_beatcounter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Clear,
    input  logic             En,
    output logic [WIDTH-1:0] Count,
    output logic             Last
);

    logic [WIDTH-1:0] count_q;

    // Beats per line is a power of two, so natural overflow gives the wrap.
    always_ff @(posedge clk) begin
        if (reset || Clear) begin
            count_q <= '0;
        end else if (En) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign Count = count_q;
    assign Last  = &count_q;

endmodule

// File: rtl/linefill_engine.sv
// Cache line fill / writeback engine: turns one line request into a beat burst.
// Latency: burst starts the cycle after a request in IDLE; ack on the last accepted beat.
// Backpressure: BusValid/BusAdr hold until BusReady; any number of wait states allowed.
// Ports: cache side (CacheBusRW/Adr, ReadDataWord, CacheBusAck, SelBusBeat, BeatCount,
// FetchBuffer, BusCommitted), bus side (BusValid/Write/Adr/WData, BusReady, BusRData).
module linefill_engine
    import linefill_engine_pkg::*;
#(
    parameter int PA_BITS = 56,
    parameter int LINELEN = DEF_LINELEN,
    parameter int BEATLEN = DEF_BEATLEN,
    parameter int LOGBWPL = $clog2(LINELEN / BEATLEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Stall,
    input  logic               FlushStage,
    input  logic [1:0]         CacheBusRW,
    input  logic [PA_BITS-1:0] CacheBusAdr,
    input  logic [BEATLEN-1:0] ReadDataWord,
    output logic               CacheBusAck,
    output logic               SelBusBeat,
    output logic [LOGBWPL-1:0] BeatCount,
    output logic [LINELEN-1:0] FetchBuffer,
    output logic               BusCommitted,
    output logic               BusValid,
    output logic               BusWrite,
    output logic [PA_BITS-1:0] BusAdr,
    output logic [BEATLEN-1:0] BusWData,
    input  logic               BusReady,
    input  logic [BEATLEN-1:0] BusRData
);

    localparam int NBEATS  = beats_per_line(LINELEN, BEATLEN);
    localparam int LINEOFF = $clog2(LINELEN / 8);
    localparam int BEATOFF = $clog2(BEATLEN / 8);

    busstate_t                state_q, state_d;
    logic                     write_q, write_d;
    logic [PA_BITS-1:LINEOFF] line_q, line_d;

    logic in_burst;
    logic last_beat;
    logic beat_accept;
    logic rd_beat;

    // Stall only matters to the requesting stage; the burst itself never waits on it.
    logic unused_ok;
    assign unused_ok = &{1'b0, Stall, CacheBusAdr[LINEOFF-1:0]};

    assign in_burst    = (state_q == STATE_BURST);
    assign beat_accept = in_burst & BusReady;
    assign rd_beat     = beat_accept & ~write_q;

    linefill_engine_beatcounter #(
        .WIDTH(LOGBWPL)
    ) u_beatcounter (
        .clk  (clk),
        .reset(reset),
        .Clear(~in_burst),
        .En   (beat_accept),
        .Count(BeatCount),
        .Last (last_beat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_IDLE;
            write_q <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        line_d      = line_q;
        CacheBusAck = 1'b0;
        unique case (state_q)
            STATE_IDLE: begin
                // A flushed stage must not launch a burst; 2'b11 falls through as a fetch.
                if ((CacheBusRW != 2'b00) && !FlushStage) begin
                    state_d = STATE_BURST;
                    write_d = (CacheBusRW == 2'b01);
                    line_d  = CacheBusAdr[PA_BITS-1:LINEOFF];
                end
            end
            STATE_BURST: begin
                if (BusReady && last_beat) begin
                    CacheBusAck = 1'b1;
                    state_d     = STATE_DONE;
                end
            end
            STATE_DONE: begin
                // The cache still shows its old request here; ignoring it prevents a replay.
                state_d = STATE_IDLE;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    assign SelBusBeat   = in_burst & write_q;
    assign BusCommitted = (state_q != STATE_IDLE);
    assign BusValid     = in_burst;
    assign BusWrite     = in_burst & write_q;
    assign BusAdr       = {line_q, BeatCount, {BEATOFF{1'b0}}};
    assign BusWData     = SelBusBeat ? ReadDataWord : '0;

    // One enable-gated register slice per beat; only the addressed slice loads.
    for (genvar b = 0; b < NBEATS; b++) begin : g_slice
        logic               slice_en;
        logic [BEATLEN-1:0] slice_q;

        assign slice_en = rd_beat & (BeatCount == LOGBWPL'(b));

        always_ff @(posedge clk) begin
            if (reset) begin
                slice_q <= '0;
            end else if (slice_en) begin
                slice_q <= BusRData;
            end
        end

        assign FetchBuffer[b*BEATLEN +: BEATLEN] = slice_q;
    end

endmodule
